// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch sequencer states, fault codes and
// architectural constants used by the PC / fetch logic.
package cpu_pkg;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  // Fault codes reported on fault_code.
  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b01;
  localparam logic [1:0] FAULT_MISALIGN = 2'b10;

  // Instruction size in bytes; sequential fetch advances by this amount.
  localparam int unsigned INST_BYTES = 4;

  // Default PC loaded on reset.
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // True when an address is not aligned to an instruction boundary.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage : cpu_pkg

// File: rtl/fetch_watchdog.sv
// Fetch watchdog: counts consecutive FETCH cycles in which instruction
// memory has not answered, and flags the cycle that exhausts the budget.
// A TIMEOUT of 0 disables the watchdog entirely.
module fetch_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic active,       // sequencer is in FETCH this cycle
  input  logic ready,        // imem_ready
  output logic timeout_hit
);

  // Counter wide enough to hold TIMEOUT, never narrower than one bit.
  localparam int W = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam bit ENABLED = (TIMEOUT > 0);

  logic [W-1:0] wait_cnt;

  // Count unanswered fetch cycles; any answer or any non-FETCH cycle clears.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, independent of block ordering.
    if (rst) begin
      wait_cnt <= '0;
    end else if (ENABLED && active && !ready) begin
      wait_cnt <= wait_cnt + W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  // A ready response in the same cycle always beats the timeout.
  assign timeout_hit = ENABLED && active && !ready && (wait_cnt == LAST);

endmodule : fetch_watchdog

// File: rtl/pc_fetch_reg.sv
// Program-counter register and instruction-fetch sequencer.
// Holds the architectural PC, issues instruction-memory requests, commits
// the next PC when a fetch completes without a stall, and latches a sticky
// fault on a misaligned target or a fetch timeout.
module pc_fetch_reg
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] next_pc,
  input  logic        stall,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] retire_cnt,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [31:0] fault_pc
);

  fetch_state_t state, state_next;

  logic in_fetch;
  logic commit;
  logic target_bad;
  logic timeout_hit;

  assign in_fetch   = (state == FETCH);
  assign commit     = in_fetch && imem_ready && !stall;
  assign target_bad = is_misaligned(next_pc);

  fetch_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk         (clk),
    .rst         (rst),
    .active      (in_fetch),
    .ready       (imem_ready),
    .timeout_hit (timeout_hit)
  );

  // Sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and request/valid/fault outputs.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    state_next = state;
    imem_req   = 1'b0;
    inst_valid = 1'b0;
    fault      = 1'b0;
    unique case (state)
      IDLE: begin
        state_next = FETCH;
      end
      FETCH: begin
        imem_req   = 1'b1;
        inst_valid = imem_ready;
        if ((commit && target_bad) || timeout_hit) begin
          state_next = FAULT;
        end
      end
      FAULT: begin
        fault = 1'b1;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Architectural PC: advances only on a commit with an aligned target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (commit && !target_bad) begin
      pc <= next_pc;
    end
  end

  // Retired-instruction counter; a misaligned commit still retires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_cnt <= '0;
    end else if (commit) begin
      retire_cnt <= retire_cnt + 32'd1;
    end
  end

  // Fault record: captured once on entry to FAULT, then frozen until reset.
  // The two causes are exclusive: a commit needs imem_ready, a timeout
  // needs it low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_code <= FAULT_NONE;
      fault_pc   <= '0;
    end else if (commit && target_bad) begin
      fault_code <= FAULT_MISALIGN;
      fault_pc   <= next_pc;
    end else if (timeout_hit) begin
      fault_code <= FAULT_TIMEOUT;
      fault_pc   <= pc;
    end
  end

  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'(INST_BYTES);

endmodule : pc_fetch_reg

// File: tb/tb_pc_fetch_reg.sv
// Self-checking bench for pc_fetch_reg: directed scenarios followed by
// randomized traffic, all compared against a behavioural fetch model.
module tb_pc_fetch_reg;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] next_pc;
  logic        stall;
  logic        imem_ready;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] retire_cnt;
  logic        fault;
  logic [1:0]  fault_code;
  logic [31:0] fault_pc;

  pc_fetch_reg #(
    .RESET_PC (32'h0000_0000),
    .TIMEOUT  (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .next_pc    (next_pc),
    .stall      (stall),
    .imem_ready (imem_ready),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .inst_valid (inst_valid),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .retire_cnt (retire_cnt),
    .fault      (fault),
    .fault_code (fault_code),
    .fault_pc   (fault_pc)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // Behavioural model: "started" is false for the one post-reset cycle,
  // "halted" once any fault has been taken; misses counts consecutive
  // unanswered fetches.
  bit          m_started;
  bit          m_halted;
  int          m_misses;
  logic [31:0] m_pc;
  logic [31:0] m_retired;
  logic [1:0]  m_code;
  logic [31:0] m_fpc;

  task automatic model_reset();
    m_started = 0;
    m_halted  = 0;
    m_misses  = 0;
    m_pc      = 32'h0;
    m_retired = 32'h0;
    m_code    = 2'b00;
    m_fpc     = 32'h0;
  endtask

  task automatic check_outputs(input string where);
    bit fetching;
    fetching = m_started && !m_halted;
    check({where, ".imem_req"},   {31'b0, imem_req},   {31'b0, fetching});
    check({where, ".inst_valid"}, {31'b0, inst_valid}, {31'b0, fetching && imem_ready === 1'b1});
    check({where, ".pc"},         pc,                  m_pc);
    check({where, ".imem_addr"},  imem_addr,           m_pc);
    check({where, ".pc_plus4"},   pc_plus4,            m_pc + 32'd4);
    check({where, ".retire_cnt"}, retire_cnt,          m_retired);
    check({where, ".fault"},      {31'b0, fault},      {31'b0, m_halted});
    check({where, ".fault_code"}, {30'b0, fault_code}, {30'b0, m_code});
    check({where, ".fault_pc"},   fault_pc,            m_fpc);
  endtask

  // Apply one clock's worth of the current inputs to the model.
  task automatic model_advance();
    if (!m_started) begin
      m_started = 1;
    end else if (!m_halted) begin
      if (imem_ready) begin
        m_misses = 0;
        if (!stall) begin
          m_retired = m_retired + 1;
          if (next_pc % 4 == 0) begin
            m_pc = next_pc;
          end else begin
            m_halted = 1;
            m_code   = 2'b10;
            m_fpc    = next_pc;
          end
        end
      end else begin
        m_misses++;
        if (m_misses == TO) begin
          m_halted = 1;
          m_code   = 2'b01;
          m_fpc    = m_pc;
        end
      end
    end
  endtask

  // One cycle: inputs driven just after posedge, outputs checked at negedge.
  task automatic step(input logic s, input logic r, input logic [31:0] np, input string where);
    stall      = s;
    imem_ready = r;
    next_pc    = np;
    @(negedge clk);
    check_outputs(where);
    model_advance();
    @(posedge clk);
    #1;
  endtask

  // Assert reset between edges; outputs must clear with no clock edge.
  task automatic async_reset(input string where);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs({where, ".async"});
    @(posedge clk);
    #1;
    check_outputs({where, ".held"});
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    stall      = 1'b0;
    imem_ready = 1'b0;
    next_pc    = 32'h0;
    model_reset();
    #3;
    check_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Idle cycle after release, then streaming and stall at pc=8.
    step(1'b1, 1'b1, 32'h0, "idle");
    step(1'b0, 1'b1, m_pc + 32'd4, "stream0");
    step(1'b0, 1'b1, m_pc + 32'd4, "stream1");
    check("stream_pc8", pc, 32'h8);
    step(1'b1, 1'b1, m_pc + 32'd4, "stall0");
    step(1'b1, 1'b1, m_pc + 32'd4, "stall1");
    check("stall_pc", pc, 32'h8);
    check("stall_retire", retire_cnt, 32'd2);
    step(1'b0, 1'b1, m_pc + 32'd4, "unstall");
    check("stream_pc", pc, 32'hC);
    check("stream_retire", retire_cnt, 32'd3);

    // Misaligned target.
    step(1'b0, 1'b1, 32'h0000_0102, "misalign");
    check("mis_fault", {31'b0, fault}, 32'd1);
    check("mis_code", {30'b0, fault_code}, 32'd2);
    check("mis_fpc", fault_pc, 32'h102);
    check("mis_pc", pc, 32'hC);
    check("mis_retire", retire_cnt, 32'd4);
    step(1'b0, 1'b1, 32'h10, "frozen0");
    step(1'b0, 1'b0, 32'h10, "frozen1");
    async_reset("rst_in_fault");

    // Timeout: four unanswered fetches.
    step(1'b0, 1'b0, 32'h0, "to_idle");
    for (int i = 0; i < TO; i++) step(1'b1, 1'b0, 32'h4, "to_wait");
    check("to_fault", {31'b0, fault}, 32'd1);
    check("to_code", {30'b0, fault_code}, 32'd1);
    check("to_fpc", fault_pc, 32'h0);
    step(1'b0, 1'b0, 32'h0, "to_frozen");
    async_reset("rst_after_to");

    // Ready on the fourth cycle rescues the fetch and clears the count.
    step(1'b0, 1'b0, 32'h0, "nto_idle");
    for (int i = 0; i < TO - 1; i++) step(1'b0, 1'b0, 32'h4, "nto_wait");
    step(1'b0, 1'b1, 32'h4, "nto_ready");
    for (int i = 0; i < TO - 1; i++) step(1'b0, 1'b0, 32'h8, "nto_wait2");
    step(1'b0, 1'b1, 32'hFFFF_FFFC, "nto_ready2");
    check("nto_fault", {31'b0, fault}, 32'd0);
    check("nto_pc", pc, 32'hFFFF_FFFC);
    check("wrap_plus4", pc_plus4, 32'h0);

    // Randomized traffic; reset a few cycles after every fault.
    begin
      int fault_age;
      fault_age = 0;
      for (int n = 0; n < 3000; n++) begin
        logic        s, r;
        logic [31:0] np;
        int          pick;
        s    = ($urandom_range(0, 3) == 0);
        r    = ($urandom_range(0, 9) < 7);
        pick = $urandom_range(0, 59);
        if (pick == 0)      np = {$urandom(), 2'b00} | 32'(($urandom_range(1, 3)));
        else if (pick == 1) np = 32'hFFFF_FFFC;
        else if (pick < 10) np = {$urandom(), 2'b00};
        else                np = m_pc + 32'd4;
        step(s, r, np, "rand");
        if (m_halted) fault_age++;
        if (fault_age > 3 || $urandom_range(0, 499) == 0) begin
          async_reset("rand_rst");
          fault_age = 0;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_pc_fetch_reg
